// File: rtl/vx_tlb_ptw_pkg.sv
// Shared Sv32 page-table-walker types: PTE layout, walker states and PTE address helper.
package vx_tlb_ptw_pkg;

  localparam int SV32_LEVELS    = 2;
  localparam int VPN_SLICE_W    = 10;
  localparam int PTE_BYTES      = 4;
  localparam int PAGE_OFFSET_W  = 12;
  localparam int PTE_PPN_W      = 22;
  localparam int SV32_VPN_W     = SV32_LEVELS * VPN_SLICE_W;
  localparam int PTE_FULL_ADDR_W = PTE_PPN_W + PAGE_OFFSET_W;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    PTW_IDLE,
    PTW_L1_REQ,
    PTW_L1_WAIT,
    PTW_L0_REQ,
    PTW_L0_WAIT,
    PTW_UPDATE
  } ptw_state_e;

  // Not-valid, or writable without readable (reserved encoding).
  function automatic logic pte_bad(pte_t p);
    return !p[PTE_V] || (!p[PTE_R] && p[PTE_W]);
  endfunction

  function automatic logic pte_leaf(pte_t p);
    return p[PTE_R] || p[PTE_X];
  endfunction

  function automatic logic [PTE_FULL_ADDR_W-1:0] pte_addr(logic [PTE_PPN_W-1:0]   ppn,
                                                          logic [VPN_SLICE_W-1:0] idx);
    return {ppn, {PAGE_OFFSET_W{1'b0}}}
         + PTE_FULL_ADDR_W'(idx) * PTE_FULL_ADDR_W'(PTE_BYTES);
  endfunction

endpackage

// File: rtl/vx_tlb_ptw_rr_arbiter.sv
// Round-robin arbiter; the priority pointer moves just past the winner when advance is set.
module vx_tlb_ptw_rr_arbiter #(
  parameter  int NUM_REQS = 4,
  localparam int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [IDX_W-1:0] ptr;

  // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = (int'(ptr) + i) % NUM_REQS;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : IDX_W'(grant_idx + 1'b1);
    end
  end

endmodule

// File: rtl/vx_tlb_ptw.sv
// Sv32 two-level page-table walker serving NUM_BANKS TLB miss ports, one walk in flight.
// Optional one-entry L1 PTE cache enabled by defining PTW_L1_CACHE_EN.
module vx_tlb_ptw
  import vx_tlb_ptw_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int MEM_ADDR_W = 32,
  parameter int VPN_WIDTH  = SV32_VPN_W,
  parameter int PPN_WIDTH  = 20
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PTE_PPN_W-1:0]           satp_ppn,
  input  logic                           flush,
  input  logic [NUM_BANKS-1:0]           tlb_miss_valid,
  input  logic [NUM_BANKS*VPN_WIDTH-1:0] tlb_miss_vpn,
  output logic [NUM_BANKS-1:0]           tlb_miss_ready,
  output logic [NUM_BANKS-1:0]           tlb_update_valid,
  output logic [NUM_BANKS*VPN_WIDTH-1:0] tlb_update_vpn,
  output logic [NUM_BANKS*PPN_WIDTH-1:0] tlb_update_ppn,
  output logic [NUM_BANKS-1:0]           tlb_update_fault,
  input  logic [NUM_BANKS-1:0]           tlb_update_ready,
  output logic                           mem_req_valid,
  output logic [MEM_ADDR_W-1:0]          mem_req_addr,
  input  logic                           mem_req_ready,
  input  logic                           mem_rsp_valid,
  input  logic [31:0]                    mem_rsp_data,
  output logic                           mem_rsp_ready
);

  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  ptw_state_e                  state;
  logic [IDX_W-1:0]            bank_q;
  logic [VPN_WIDTH-1:0]        vpn_q;
  logic [PPN_WIDTH-1:0]        ppn_q;
  logic                        fault_q;
  logic [NUM_BANKS-1:0]        grant;
  logic [IDX_W-1:0]            grant_idx;
  logic                        grant_valid;
  logic [VPN_WIDTH-1:0]        grant_vpn;
  logic                        cache_hit;
  logic [PTE_PPN_W-1:0]        cache_ppn;
  logic [PTE_FULL_ADDR_W-1:0]  l1_full, hit_full, l0_full;
  logic [PTE_PPN_W-1:0]        rsp_ppn, super_ppn;
  pte_t                        rsp_pte;
  logic                        l1_fill;
  logic                        unused_pte_bits;

  vx_tlb_ptw_rr_arbiter #(.NUM_REQS(NUM_BANKS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (tlb_miss_valid),
    .advance     (state == PTW_IDLE),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_vpn  = tlb_miss_vpn[grant_idx*VPN_WIDTH +: VPN_WIDTH];
  assign rsp_pte    = pte_t'(mem_rsp_data);
  assign rsp_ppn    = {rsp_pte.ppn1, rsp_pte.ppn0};
  assign super_ppn  = {rsp_pte.ppn1, vpn_q[VPN_SLICE_W-1:0]};
  assign l1_full    = pte_addr(satp_ppn, grant_vpn[2*VPN_SLICE_W-1:VPN_SLICE_W]);
  assign hit_full   = pte_addr(cache_ppn, grant_vpn[VPN_SLICE_W-1:0]);
  assign l0_full    = pte_addr(rsp_ppn, vpn_q[VPN_SLICE_W-1:0]);
  assign l1_fill    = (state == PTW_L1_WAIT) && mem_rsp_valid && !pte_bad(rsp_pte) && !pte_leaf(rsp_pte);
  assign unused_pte_bits = ^{rsp_pte.rsw, rsp_pte.d, rsp_pte.a, rsp_pte.g, rsp_pte.u};

`ifdef PTW_L1_CACHE_EN
  logic                   cache_valid;
  logic [VPN_SLICE_W-1:0] cache_vpn1;
  logic [PTE_PPN_W-1:0]   cache_root;
  logic [PTE_PPN_W-1:0]   root_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cache_valid <= 1'b0;
    end else if (l1_fill) begin
      cache_valid <= 1'b1;
    end
  end

  // NOTE: cache payload needs no reset; cache_valid alone gates every use of it.
  always_ff @(posedge clk) begin
    if (state == PTW_IDLE && grant_valid) begin
      root_q <= satp_ppn;
    end
    if (l1_fill) begin
      cache_vpn1 <= vpn_q[2*VPN_SLICE_W-1:VPN_SLICE_W];
      cache_root <= root_q;
      cache_ppn  <= rsp_ppn;
    end
  end

  // A flush coinciding with the grant must not reuse the entry being invalidated.
  assign cache_hit = cache_valid && !flush && (cache_root == satp_ppn)
                   && (cache_vpn1 == grant_vpn[2*VPN_SLICE_W-1:VPN_SLICE_W]);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign cache_hit    = 1'b0;
  assign cache_ppn    = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PTW_IDLE;
      bank_q       <= '0;
      vpn_q        <= '0;
      ppn_q        <= '0;
      fault_q      <= 1'b0;
      mem_req_addr <= '0;
    end else begin
      case (state)
        PTW_IDLE: if (grant_valid) begin
          bank_q  <= grant_idx;
          vpn_q   <= grant_vpn;
          ppn_q   <= '0;
          fault_q <= 1'b0;
          if (cache_hit) begin
            mem_req_addr <= hit_full[MEM_ADDR_W-1:0];
            state        <= PTW_L0_REQ;
          end else begin
            mem_req_addr <= l1_full[MEM_ADDR_W-1:0];
            state        <= PTW_L1_REQ;
          end
        end
        PTW_L1_REQ: if (mem_req_ready) state <= PTW_L1_WAIT;
        PTW_L1_WAIT: if (mem_rsp_valid) begin
          if (pte_bad(rsp_pte) || (pte_leaf(rsp_pte) && rsp_pte.ppn0 != '0)) begin
            fault_q <= 1'b1;
            state   <= PTW_UPDATE;
          end else if (pte_leaf(rsp_pte)) begin
            ppn_q <= super_ppn[PPN_WIDTH-1:0];
            state <= PTW_UPDATE;
          end else begin
            mem_req_addr <= l0_full[MEM_ADDR_W-1:0];
            state        <= PTW_L0_REQ;
          end
        end
        PTW_L0_REQ: if (mem_req_ready) state <= PTW_L0_WAIT;
        PTW_L0_WAIT: if (mem_rsp_valid) begin
          if (pte_bad(rsp_pte) || !pte_leaf(rsp_pte)) fault_q <= 1'b1;
          else                                        ppn_q   <= rsp_ppn[PPN_WIDTH-1:0];
          state <= PTW_UPDATE;
        end
        PTW_UPDATE: if (tlb_update_ready[bank_q]) state <= PTW_IDLE;
        default: state <= PTW_IDLE;
      endcase
    end
  end

  assign tlb_miss_ready   = (state == PTW_IDLE && !reset) ? grant : '0;
  assign mem_req_valid    = (state == PTW_L1_REQ) || (state == PTW_L0_REQ);
  assign mem_rsp_ready    = 1'b1;
  assign tlb_update_valid = (state == PTW_UPDATE) ? (NUM_BANKS'(1) << bank_q) : '0;
  assign tlb_update_vpn   = {NUM_BANKS{vpn_q}};
  assign tlb_update_ppn   = {NUM_BANKS{ppn_q}};
  assign tlb_update_fault = tlb_update_valid & {NUM_BANKS{fault_q}};

endmodule

// File: tb/tb_vx_tlb_ptw.sv
// Directed bench for vx_tlb_ptw; L1-cache expectations follow PTW_L1_CACHE_EN.
module tb_vx_tlb_ptw;

`ifdef PTW_L1_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] satp_ppn;
  logic        flush;
  logic [3:0]  tlb_miss_valid;
  logic [79:0] tlb_miss_vpn;
  logic [3:0]  tlb_miss_ready;
  logic [3:0]  tlb_update_valid;
  logic [79:0] tlb_update_vpn;
  logic [79:0] tlb_update_ppn;
  logic [3:0]  tlb_update_fault;
  logic [3:0]  tlb_update_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_ready;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] mem_tbl [logic [31:0]];
  logic [31:0] req_log [$];
  bit          pending, drop, inject;
  logic [31:0] pend_addr, inject_data;

  always #5 clk = ~clk;

  vx_tlb_ptw dut (
    .clk(clk), .reset(reset), .satp_ppn(satp_ppn), .flush(flush),
    .tlb_miss_valid(tlb_miss_valid), .tlb_miss_vpn(tlb_miss_vpn), .tlb_miss_ready(tlb_miss_ready),
    .tlb_update_valid(tlb_update_valid), .tlb_update_vpn(tlb_update_vpn),
    .tlb_update_ppn(tlb_update_ppn), .tlb_update_fault(tlb_update_fault),
    .tlb_update_ready(tlb_update_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready)
  );

  // Memory model: logs each accepted request and answers it in the following cycle.
  always @(negedge clk) begin
    #2;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (inject) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inject_data;
    end else if (pending && !drop) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_tbl.exists(pend_addr) ? mem_tbl[pend_addr] : 32'h0;
    end
    pending = 1'b0;
    if (mem_req_valid && mem_req_ready && !reset) begin
      req_log.push_back(mem_req_addr);
      pending   = 1'b1;
      pend_addr = mem_req_addr;
    end
  end

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic do_walk(input string name, input int b, input logic [21:0] satp,
                         input logic [19:0] vpn, input logic [19:0] e_ppn, input bit e_fault,
                         input int e_nreq, input logic [31:0] e_addr0, input int stall);
    int t;
    req_log.delete();
    @(negedge clk);
    satp_ppn = satp;
    tlb_miss_vpn[b*20 +: 20] = vpn;
    tlb_miss_valid[b] = 1'b1;
    if (stall > 0) mem_req_ready = 1'b0;
    #1;
    t = 0;
    while (!tlb_miss_ready[b] && t < 50) begin @(negedge clk); #1; t++; end
    vectors++;
    if (tlb_miss_ready !== (4'b0001 << b)) begin
      errors++;
      $display("FAIL %s grant: miss_ready=%b required %b", name, tlb_miss_ready, 4'b0001 << b);
      tlb_miss_valid[b] = 1'b0;
      mem_req_ready = 1'b1;
      return;
    end
    @(posedge clk); @(negedge clk);
    tlb_miss_valid[b] = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      #1;
      vectors++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== e_addr0) begin
        errors++;
        $display("FAIL %s req_hold: valid=%b addr=%h required 1 %h", name, mem_req_valid, mem_req_addr, e_addr0);
      end
      mem_req_ready = 1'b1;
    end
    #1;
    t = 0;
    while (tlb_update_valid == '0 && t < 100) begin @(negedge clk); #1; t++; end
    vectors++;
    if (tlb_update_valid !== (4'b0001 << b) || tlb_update_vpn[b*20 +: 20] !== vpn ||
        tlb_update_ppn[b*20 +: 20] !== e_ppn || tlb_update_fault[b] !== e_fault) begin
      errors++;
      $display("FAIL %s update: valid=%b vpn=%h ppn=%h fault=%b required %b %h %h %b", name,
               tlb_update_valid, tlb_update_vpn[b*20 +: 20], tlb_update_ppn[b*20 +: 20],
               tlb_update_fault[b], 4'b0001 << b, vpn, e_ppn, e_fault);
    end
    if (e_nreq > 0) begin
      vectors++;
      if (req_log.size() != e_nreq || req_log[0] !== e_addr0) begin
        errors++;
        $display("FAIL %s mem_reqs: count=%0d first=%h required %0d %h", name, req_log.size(),
                 (req_log.size() > 0) ? req_log[0] : 32'hx, e_nreq, e_addr0);
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; satp_ppn = '0; tlb_miss_vpn = '0;
    tlb_miss_valid = 4'hF; tlb_update_ready = 4'hF; mem_req_ready = 1'b1;
    drop = 1'b0; inject = 1'b0; inject_data = '0; pending = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (tlb_miss_ready !== 4'h0 || tlb_update_valid !== 4'h0 || mem_req_valid !== 1'b0 ||
        mem_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: miss_ready=%b upd_valid=%b req_valid=%b rsp_ready=%b required 0 0 0 1",
               tlb_miss_ready, tlb_update_valid, mem_req_valid, mem_rsp_ready);
    end
    tlb_miss_valid = 4'h0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_two_level();
    do_walk("t1_two_level", 0, 22'h100, 20'h00401, 20'h12345, 1'b0, 2, 32'h0010_0004, 3);
    vectors++;
    if (req_log.size() < 2 || req_log[1] !== 32'h0008_0004) begin
      errors++;
      $display("FAIL t1_l0_addr: got=%h required 00080004", (req_log.size() > 1) ? req_log[1] : 32'hx);
    end
  endtask

  task automatic test_superpage_and_faults();
    do_walk("t2_superpage",  0, 22'h200, 20'h00401, 20'h80001, 1'b0, 1, 32'h0020_0004, 0);
    do_walk("t3_misaligned", 1, 22'h300, 20'h00401, 20'h00000, 1'b1, 1, 32'h0030_0004, 0);
    do_walk("t3b_invalid",   2, 22'h400, 20'h00401, 20'h00000, 1'b1, 1, 32'h0040_0004, 0);
    do_walk("t3c_w_no_r",    3, 22'h500, 20'h00401, 20'h00000, 1'b1, 1, 32'h0050_0004, 0);
    do_walk("t3d_l0_ptr",    0, 22'h600, 20'h00401, 20'h00000, 1'b1, 2, 32'h0060_0004, 0);
  endtask

  task automatic test_back_to_back();
    int t;
    bit stable;
    pulse_reset();
    @(negedge clk);
    satp_ppn = 22'h100;
    for (int b = 0; b < 4; b++) tlb_miss_vpn[b*20 +: 20] = 20'h00402 + 20'(b);
    tlb_miss_valid   = 4'hF;
    tlb_update_ready = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      #1;
      t = 0;
      while (tlb_miss_ready == '0 && t < 100) begin @(negedge clk); #1; t++; end
      vectors++;
      if (tlb_miss_ready !== (4'b0001 << k)) begin
        errors++;
        $display("FAIL t4_grant%0d: miss_ready=%b required %b", k, tlb_miss_ready, 4'b0001 << k);
      end
      @(posedge clk); @(negedge clk);
      tlb_miss_valid[k] = 1'b0;
      #1;
      t = 0;
      while (tlb_update_valid == '0 && t < 100) begin @(negedge clk); #1; t++; end
      vectors++;
      if (tlb_update_valid !== (4'b0001 << k) || tlb_update_ppn[k*20 +: 20] !== 20'h00200 + 20'(k) ||
          tlb_update_fault !== 4'h0) begin
        errors++;
        $display("FAIL t4_update%0d: valid=%b ppn=%h fault=%b required %b %h 0000", k, tlb_update_valid,
                 tlb_update_ppn[k*20 +: 20], tlb_update_fault, 4'b0001 << k, 20'h00200 + 20'(k));
      end
      if (k == 2) begin
        stable = 1'b1;
        repeat (5) begin
          @(negedge clk); #1;
          if (tlb_update_valid !== 4'b0100 || tlb_update_ppn[40 +: 20] !== 20'h00202 ||
              tlb_miss_ready !== 4'h0 || mem_req_valid !== 1'b0) stable = 1'b0;
        end
        vectors++;
        if (!stable) begin
          errors++;
          $display("FAIL t4_stall: outputs changed or new grant while bank2 not ready, required stable");
        end
        tlb_update_ready[2] = 1'b1;
      end
      @(posedge clk); @(negedge clk);
    end
    tlb_update_ready = 4'hF;
  endtask

  task automatic test_reset_mid_walk();
    int t;
    bit bad;
    drop = 1'b1;
    req_log.delete();
    @(negedge clk);
    satp_ppn = 22'h100;
    tlb_miss_vpn[20 +: 20] = 20'h00401;
    tlb_miss_valid[1] = 1'b1;
    #1;
    t = 0;
    while (!tlb_miss_ready[1] && t < 50) begin @(negedge clk); #1; t++; end
    @(posedge clk); @(negedge clk);
    tlb_miss_valid[1] = 1'b0;
    t = 0;
    while (req_log.size() == 0 && t < 50) begin @(negedge clk); #3; t++; end
    vectors++;
    if (req_log.size() != 1) begin
      errors++;
      $display("FAIL t5_l1_req: count=%0d required 1", req_log.size());
    end
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; inject = 1'b1; inject_data = 32'h048D_140F;
    @(negedge clk); inject = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (tlb_update_valid !== 4'h0 || mem_req_valid !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      errors++;
      $display("FAIL t5_abort: update or mem request after reset, required none");
    end
    drop = 1'b0;
    do_walk("t5_recover", 1, 22'h100, 20'h00401, 20'h12345, 1'b0, 2, 32'h0010_0004, 0);
  endtask

  task automatic test_l1_cache();
    pulse_flush();
    do_walk("t6_fill", 0, 22'h100, 20'h00401, 20'h12345, 1'b0, 2, 32'h0010_0004, 0);
    do_walk("t6_hit",  3, 22'h100, 20'h00402, 20'h00200, 1'b0, CACHE ? 1 : 2,
            CACHE ? 32'h0008_0008 : 32'h0010_0004, 0);
    pulse_flush();
    do_walk("t6_flushed", 2, 22'h100, 20'h00402, 20'h00200, 1'b0, 2, 32'h0010_0004, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    mem_tbl[32'h0010_0004] = 32'h0002_0001;  // non-leaf -> table at PPN 0x80
    mem_tbl[32'h0008_0004] = 32'h048D_140F;  // leaf PPN 0x12345
    mem_tbl[32'h0020_0004] = 32'h2000_000F;  // superpage PPN1=0x200
    mem_tbl[32'h0030_0004] = 32'h2000_040F;  // superpage with PPN0!=0
    mem_tbl[32'h0040_0004] = 32'h0000_000E;  // V=0
    mem_tbl[32'h0050_0004] = 32'h0000_0005;  // W without R
    mem_tbl[32'h0060_0004] = 32'h0003_0001;  // non-leaf -> table at PPN 0xC0
    mem_tbl[32'h000C_0004] = 32'h0000_0001;  // non-leaf at L0
    for (int b = 0; b < 4; b++)
      mem_tbl[32'h0008_0008 + 32'(4*b)] = ((32'h200 + 32'(b)) << 10) | 32'hB;

    test_reset();
    test_two_level();
    test_superpage_and_faults();
    test_back_to_back();
    test_reset_mid_walk();
    test_l1_cache();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
